// File: rtl/tfe_dispatch_pkg.sv
// Shared types and constants for the feature-address dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tfe_dispatch_pkg;

    // Default feature address width.
    localparam int ADDR_W_DEF = 12;

    // Dispatch FSM: IDLE looks for a buffered address and an idle engine,
    // OFFER holds a one-hot offer until the chosen engine accepts it.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } disp_state_t;

    // Sticky error bit positions.
    localparam int ERR_OVF  = 0;   // return arrived while local buffer full
    localparam int ERR_SPUR = 1;   // eng_done from an engine holding no job

endpackage

// File: rtl/tfe_fea_buf.sv
// Local address buffer: synchronous FIFO, DEPTH x W, with occupancy count.
// Latency: write visible at the head one cycle later; rd_dat is the current head.
// Backpressure: writes while full and reads while empty are ignored.
//   ports: clk_ext/rst_n, wr_vld/wr_dat (push), rd_rdy (pop head),
//          rd_dat (head), count, full, empty
module tfe_fea_buf #(
    parameter  int DEPTH = 4,
    parameter  int W     = 12,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_ext,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [W-1:0]     wr_dat,
    input  logic             rd_rdy,
    output logic [W-1:0]     rd_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign do_wr  = wr_vld & ~full;
    assign do_rd  = rd_rdy & ~empty;
    assign rd_dat = mem[rd_ptr];

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clk_ext) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tfe_fea_dispatcher.sv
// Pops feature addresses from the upstream FIFO, offers each to one idle engine
// (round robin), and returns the address as free once that engine reports done.
// Latency: offer one cycle after buffer write; free pulse one cycle after done.
// Backpressure: pops are credit-limited by buffer room; offers hold until eng_ready.
//   ports: clk_ext/rst_n; en, fifo_empty, rd_fifo, fea_addr(_v) to the upstream FIFO;
//          eng_valid/eng_addr/eng_ready/eng_done to engines; free_addr(_v) to tracker;
//          status busy_vec, buf_count, err[1:0] (sticky)
module tfe_fea_dispatcher
    import tfe_dispatch_pkg::*;
#(
    parameter  int N_ENG     = 4,
    parameter  int ADDR_W    = ADDR_W_DEF,
    parameter  int BUF_DEPTH = 4,
    parameter  int READ_LAT  = 2,
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk_ext,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              rd_fifo,
    input  logic [ADDR_W-1:0] fea_addr,
    input  logic              fea_addr_v,
    output logic [N_ENG-1:0]  eng_valid,
    output logic [ADDR_W-1:0] eng_addr,
    input  logic [N_ENG-1:0]  eng_ready,
    input  logic [N_ENG-1:0]  eng_done,
    output logic [ADDR_W-1:0] free_addr,
    output logic              free_addr_v,
    output logic [N_ENG-1:0]  busy_vec,
    output logic [CNT_W-1:0]  buf_count,
    output logic [1:0]        err
);

    localparam int IF_W = $clog2(READ_LAT + 1);
    localparam int RR_W = $clog2(N_ENG);

    disp_state_t       state;
    logic [RR_W-1:0]   rr;
    logic [RR_W-1:0]   g_q;
    logic [IF_W-1:0]   inflight;
    logic [N_ENG-1:0]  pend;
    logic [ADDR_W-1:0] slot [N_ENG];

    logic              ret_acc;
    logic              buf_full;
    logic              buf_empty;
    logic [ADDR_W-1:0] buf_head;
    logic              acc_hs;
    logic              pick_vld;
    logic [RR_W-1:0]   pick_idx;
    logic              free_vld;
    logic [RR_W-1:0]   free_idx;
    logic [N_ENG-1:0]  set_mask;
    logic [N_ENG-1:0]  clr_mask;

    // A return is only taken while a pop is outstanding. Returns for pops
    // issued before a reset find inflight at zero and are discarded.
    assign ret_acc = fea_addr_v & (inflight != '0);

    // Credit check counts in-flight pops so returns can never overflow the
    // buffer. Gated by reset so the strobe is low while held in reset.
    always_comb begin
        rd_fifo = rst_n & en & ~fifo_empty
                & ((int'(buf_count) + int'(inflight)) < BUF_DEPTH);
    end

    assign acc_hs = (state == OFFER) & eng_ready[g_q];

    tfe_fea_buf #(
        .DEPTH (BUF_DEPTH),
        .W     (ADDR_W)
    ) u_buf (
        .clk_ext (clk_ext),
        .rst_n   (rst_n),
        .wr_vld  (ret_acc),
        .wr_dat  (fea_addr),
        .rd_rdy  (acc_hs),
        .rd_dat  (buf_head),
        .count   (buf_count),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    // Round-robin pick: first idle engine after the last one served.
    always_comb begin
        int c;
        c        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= N_ENG; k++) begin
            c = int'(rr) + k;
            if (c >= N_ENG) begin
                c = c - N_ENG;
            end
            if (!pick_vld && !busy_vec[RR_W'(c)]) begin
                pick_vld = 1'b1;
                pick_idx = RR_W'(c);
            end
        end
    end

    // Free priority: lowest pending engine index wins.
    always_comb begin
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (pend[i]) begin
                free_vld = 1'b1;
                free_idx = RR_W'(i);
            end
        end
    end

    assign set_mask = acc_hs   ? (N_ENG'(1) << g_q)      : '0;
    assign clr_mask = free_vld ? (N_ENG'(1) << free_idx) : '0;

    // Dispatch FSM
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= RR_W'(N_ENG - 1);
            g_q       <= '0;
            eng_valid <= '0;
            eng_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!buf_empty && pick_vld) begin
                        eng_valid <= N_ENG'(1) << pick_idx;
                        eng_addr  <= buf_head;
                        g_q       <= pick_idx;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (eng_ready[g_q]) begin
                        eng_valid <= '0;
                        rr        <= g_q;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Job tracking and free emitter. Idle status is read from registered
    // busy, so a free and a new dispatch never touch the same engine at once.
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec    <= '0;
            pend        <= '0;
            free_addr   <= '0;
            free_addr_v <= 1'b0;
            for (int i = 0; i < N_ENG; i++) begin
                slot[i] <= '0;
            end
        end else begin
            busy_vec    <= (busy_vec | set_mask) & ~clr_mask;
            pend        <= (pend | (eng_done & busy_vec)) & ~clr_mask;
            free_addr_v <= free_vld;
            if (free_vld) begin
                free_addr <= slot[free_idx];
            end
            if (acc_hs) begin
                slot[g_q] <= eng_addr;
            end
        end
    end

    // Credit counter and sticky errors
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            err      <= '0;
        end else begin
            if (rd_fifo && !ret_acc) begin
                inflight <= inflight + IF_W'(1);
            end else if (!rd_fifo && ret_acc) begin
                inflight <= inflight - IF_W'(1);
            end
            if (ret_acc && buf_full) begin
                err[ERR_OVF] <= 1'b1;
            end
            if ((eng_done & ~busy_vec) != '0) begin
                err[ERR_SPUR] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tfe_fea_dispatcher.sv
// Directed bench for tfe_fea_dispatcher: an upstream FIFO model with fixed read
// latency feeds the DUT; expected offers and frees go into queues that a
// negedge monitor pops and compares when the DUT presents them.
module tb_tfe_fea_dispatcher;

    localparam int N_ENG     = 4;
    localparam int ADDR_W    = 12;
    localparam int BUF_DEPTH = 4;
    localparam int READ_LAT  = 2;

    typedef struct packed {
        logic [N_ENG-1:0]  mask;
        logic [ADDR_W-1:0] addr;
    } disp_t;

    logic              clk_ext;
    logic              rst_n;
    logic              en;
    logic              fifo_empty;
    logic              rd_fifo;
    logic [ADDR_W-1:0] fea_addr;
    logic              fea_addr_v;
    logic [N_ENG-1:0]  eng_valid;
    logic [ADDR_W-1:0] eng_addr;
    logic [N_ENG-1:0]  eng_ready;
    logic [N_ENG-1:0]  eng_done;
    logic [ADDR_W-1:0] free_addr;
    logic              free_addr_v;
    logic [N_ENG-1:0]  busy_vec;
    logic [2:0]        buf_count;
    logic [1:0]        err;

    int n_cmp;
    int n_bad;
    int pop_cnt;

    logic [ADDR_W-1:0] up_q [$];
    disp_t             exp_disp [$];
    logic [ADDR_W-1:0] exp_free [$];

    tfe_fea_dispatcher #(
        .N_ENG     (N_ENG),
        .ADDR_W    (ADDR_W),
        .BUF_DEPTH (BUF_DEPTH),
        .READ_LAT  (READ_LAT)
    ) dut (
        .clk_ext     (clk_ext),
        .rst_n       (rst_n),
        .en          (en),
        .fifo_empty  (fifo_empty),
        .rd_fifo     (rd_fifo),
        .fea_addr    (fea_addr),
        .fea_addr_v  (fea_addr_v),
        .eng_valid   (eng_valid),
        .eng_addr    (eng_addr),
        .eng_ready   (eng_ready),
        .eng_done    (eng_done),
        .free_addr   (free_addr),
        .free_addr_v (free_addr_v),
        .busy_vec    (busy_vec),
        .buf_count   (buf_count),
        .err         (err)
    );

    initial begin
        clk_ext = 1'b0;
        forever #5 clk_ext = ~clk_ext;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // Upstream FIFO: data for a pop seen at edge N is presented READ_LAT cycles later.
    initial begin : upstream
        logic              rd_s;
        logic              pv [READ_LAT];
        logic [ADDR_W-1:0] pa [READ_LAT];
        fea_addr_v = 1'b0;
        fea_addr   = '0;
        fifo_empty = 1'b1;
        pop_cnt    = 0;
        for (int k = 0; k < READ_LAT; k++) begin
            pv[k] = 1'b0;
            pa[k] = '0;
        end
        forever begin
            @(posedge clk_ext);
            rd_s = rd_fifo;
            #1;
            for (int k = READ_LAT - 1; k > 0; k--) begin
                pv[k] = pv[k-1];
                pa[k] = pa[k-1];
            end
            if (rd_s && up_q.size() > 0) begin
                pv[0] = 1'b1;
                pa[0] = up_q.pop_front();
                pop_cnt++;
            end else begin
                pv[0] = 1'b0;
                pa[0] = '0;
            end
            fea_addr_v = pv[READ_LAT-1];
            fea_addr   = pa[READ_LAT-1];
            fifo_empty = (up_q.size() == 0);
        end
    end

    // Scoreboard monitor
    always @(negedge clk_ext) begin : mon
        disp_t             d;
        logic [ADDR_W-1:0] fa;
        if (rst_n && (eng_valid & eng_ready) != '0) begin
            check("disp_expected", exp_disp.size() != 0, 1);
            check("disp_onehot", $countones(eng_valid), 1);
            if (exp_disp.size() != 0) begin
                d = exp_disp.pop_front();
                check("disp_eng", eng_valid & eng_ready, d.mask);
                check("disp_addr", eng_addr, d.addr);
            end
        end
        if (rst_n && free_addr_v) begin
            check("free_expected", exp_free.size() != 0, 1);
            if (exp_free.size() != 0) begin
                fa = exp_free.pop_front();
                check("free_addr", free_addr, fa);
            end
        end
    end

    task automatic step();
        @(posedge clk_ext);
        #1;
    endtask

    task automatic exp_d(input logic [N_ENG-1:0] m, input logic [ADDR_W-1:0] a);
        disp_t d;
        d.mask = m;
        d.addr = a;
        exp_disp.push_back(d);
    endtask

    task automatic wait_disp(input int max_cyc, input string nm);
        int n = 0;
        while (exp_disp.size() != 0 && n < max_cyc) begin
            @(negedge clk_ext);
            n++;
        end
        check(nm, exp_disp.size(), 0);
    endtask

    task automatic wait_offer(input int max_cyc, input string nm);
        int n = 0;
        @(negedge clk_ext);
        while (eng_valid == '0 && n < max_cyc) begin
            @(negedge clk_ext);
            n++;
        end
        check(nm, eng_valid != '0, 1);
    endtask

    initial begin : stim
        int p0;
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        eng_ready = '0;
        eng_done  = '0;
        repeat (3) @(posedge clk_ext);
        #1;
        check("rst_rd_fifo", rd_fifo, 0);
        check("rst_eng_valid", eng_valid, 0);
        check("rst_eng_addr", eng_addr, 0);
        check("rst_free_v", free_addr_v, 0);
        check("rst_free_addr", free_addr, 0);
        check("rst_busy", busy_vec, 0);
        check("rst_buf_count", buf_count, 0);
        check("rst_err", err, 0);
        @(negedge clk_ext);
        rst_n = 1'b1;
        step();

        // 1: three addresses, ready tied high, round robin from engine 0
        p0 = pop_cnt;
        eng_ready = 4'b1111;
        exp_d(4'b0001, 12'h010);
        exp_d(4'b0010, 12'h011);
        exp_d(4'b0100, 12'h012);
        up_q.push_back(12'h010);
        up_q.push_back(12'h011);
        up_q.push_back(12'h012);
        en = 1'b1;
        wait_disp(40, "t1_dispatch_done");
        step();
        step();
        check("t1_pops", pop_cnt - p0, 3);
        check("t1_busy", busy_vec, 4'b0111);
        check("t1_buf_count", buf_count, 0);

        // 2: fill engine 3, then all busy: credit limit stops at BUF_DEPTH pops
        exp_d(4'b1000, 12'h013);
        up_q.push_back(12'h013);
        wait_disp(40, "t2_eng3_dispatch");
        step();
        step();
        check("t2_busy_all", busy_vec, 4'b1111);
        p0 = pop_cnt;
        for (int i = 0; i < 6; i++) begin
            up_q.push_back(ADDR_W'(12'h020 + i));
        end
        repeat (15) step();
        check("t2_pops", pop_cnt - p0, 4);
        check("t2_buf_count", buf_count, 4);
        check("t2_rd_fifo_low", rd_fifo, 0);
        check("t2_no_offer", eng_valid, 0);
        check("t2_err0", err[0], 0);

        // 3: engine 1 freed, then holds ready low while others assert ready
        eng_ready = 4'b1101;
        exp_free.push_back(12'h011);
        eng_done = 4'b0010;
        step();
        eng_done = '0;
        wait_offer(10, "t3_offer_seen");
        check("t3_offer_eng", eng_valid, 4'b0010);
        check("t3_offer_addr", eng_addr, 12'h020);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_ext);
            check("t3_hold_valid", eng_valid, 4'b0010);
            check("t3_hold_addr", eng_addr, 12'h020);
            check("t3_hold_buf", buf_count, 4);
        end
        exp_d(4'b0010, 12'h020);
        @(posedge clk_ext);
        #1;
        eng_ready = 4'b1111;
        @(posedge clk_ext);
        #1;
        eng_ready = '0;
        @(negedge clk_ext);
        check("t3_pop_once", buf_count, 3);
        check("t3_valid_clear", eng_valid, 0);
        wait_disp(5, "t3_accept");
        repeat (5) step();
        check("t3_refill", buf_count, 4);
        check("t3_busy", busy_vec, 4'b1111);

        // 4: simultaneous done on engines 0, 2, 3 -> frees in index order
        exp_free.push_back(12'h010);
        exp_free.push_back(12'h012);
        exp_free.push_back(12'h013);
        eng_done = 4'b1101;
        step();
        eng_done = '0;
        @(negedge clk_ext);
        check("t4_busy_c1", busy_vec, 4'b1111);
        check("t4_free_v_c1", free_addr_v, 0);
        @(negedge clk_ext);
        check("t4_busy_c2", busy_vec, 4'b1110);
        check("t4_free_v_c2", free_addr_v, 1);
        @(negedge clk_ext);
        check("t4_busy_c3", busy_vec, 4'b1010);
        check("t4_free_v_c3", free_addr_v, 1);
        @(negedge clk_ext);
        check("t4_busy_c4", busy_vec, 4'b0010);
        check("t4_free_v_c4", free_addr_v, 1);
        @(negedge clk_ext);
        check("t4_free_v_c5", free_addr_v, 0);
        check("t4_free_q", exp_free.size(), 0);

        // 5: done from idle engine 3 -> sticky err[1], no free pulse
        step();
        eng_done = 4'b1000;
        step();
        eng_done = '0;
        @(negedge clk_ext);
        check("t5_err_spur", err, 2'b10);
        check("t5_no_free", free_addr_v, 0);
        repeat (4) @(negedge clk_ext);
        check("t5_err_sticky", err, 2'b10);
        check("t5_no_free_late", free_addr_v, 0);

        // clean reset between scenarios
        up_q.delete();
        en = 1'b0;
        @(negedge clk_ext);
        rst_n = 1'b0;
        exp_disp.delete();
        exp_free.delete();
        #1;
        check("rstA_err", err, 0);
        check("rstA_busy", busy_vec, 0);
        @(negedge clk_ext);
        rst_n = 1'b1;
        step();

        // 6: reset during OFFER with two pops in flight
        eng_ready = '0;
        for (int i = 0; i < 5; i++) begin
            up_q.push_back(ADDR_W'(12'h030 + i));
        end
        en = 1'b1;
        wait_offer(20, "t6_offer_seen");
        check("t6_offer_eng", eng_valid, 4'b0001);
        check("t6_offer_addr", eng_addr, 12'h030);
        rst_n = 1'b0;
        exp_disp.delete();
        exp_free.delete();
        #1;
        check("t6_rst_rd_fifo", rd_fifo, 0);
        check("t6_rst_valid", eng_valid, 0);
        check("t6_rst_addr", eng_addr, 0);
        check("t6_rst_buf", buf_count, 0);
        check("t6_rst_busy", busy_vec, 0);
        en = 1'b0;
        @(negedge clk_ext);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_ext);
            check("t6_no_dispatch", eng_valid, 0);
        end
        check("t6_buf_empty", buf_count, 0);
        check("t6_err_clear", err, 0);
        step();
        exp_d(4'b0001, 12'h034);
        eng_ready = 4'b1111;
        en = 1'b1;
        wait_disp(30, "t6_new_dispatch");
        step();
        step();
        check("t6_busy", busy_vec, 4'b0001);
        check("t6_err_final", err, 0);

        check("end_disp_q", exp_disp.size(), 0);
        check("end_free_q", exp_free.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tfe_fea_dispatcher.md
Name: tfe_fea_dispatcher

Overview:
Runs in the clk_ext domain and sequences the ready-flow feature-address FIFO on behalf of several external DL engines. It pops addresses with credit control and buffers them locally. Each address goes to one idle engine under round-robin order with a valid/ready handshake. When the engine reports completion, the block returns that address to the tracker as a free address.

Parameters:
N_ENG, 4, number of external engines (2..8)
ADDR_W, 12, feature address width
BUF_DEPTH, 4, local address buffer depth (power of 2, >= READ_LAT)
READ_LAT, 2, clk_ext cycles from a rd_fifo pulse to the matching fea_addr_v pulse

Ports:
clk_ext  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  enables new pops from the upstream FIFO
fifo_empty  in  1  upstream FIFO empty (clk_ext domain)
rd_fifo  out  1  upstream pop strobe
fea_addr  in  ADDR_W  returned address
fea_addr_v  in  1  returned address valid
eng_valid  out  N_ENG  one-hot job offer
eng_addr  out  ADDR_W  job address, shared bus
eng_ready  in  N_ENG  engine accepts offer
eng_done  in  N_ENG  engine finished its job (1-cycle pulse)
free_addr  out  ADDR_W  address released to tracker
free_addr_v  out  1  free_addr valid (1-cycle pulse)
busy_vec  out  N_ENG  engine holds a job
buf_count  out  clog2(BUF_DEPTH+1)  local buffer occupancy
err  out  2  sticky: [0] buffer overflow, [1] spurious eng_done

Behaviour:
- Reset values: all outputs 0; rr pointer = N_ENG-1, so engine 0 is checked first; FSM in IDLE; buffer, pending and busy state cleared. Reset mid-handshake drops the offer and all held addresses; no free pulses are emitted for them.
- Pop control (combinational): rd_fifo = en & ~fifo_empty & (buf_count + inflight < BUF_DEPTH).
  - At most one pop per cycle.
  - inflight counts pops whose data has not yet returned. +1 on rd_fifo, -1 on fea_addr_v, unchanged when both occur in the same cycle. Range 0..READ_LAT.
- Return: fea_addr_v writes fea_addr into the buffer in the same cycle. If the buffer is full, the write is dropped and err[0] is set. Deasserting en does not cancel in-flight returns.
- Dispatch FSM:
  - IDLE: when buffer is non-empty and ~busy_vec != 0, pick the first idle engine g searching from rr+1 with wrap. Register eng_valid[g]=1 and eng_addr=buffer head, then go to OFFER. The first offer appears one cycle after the buffer write.
  - OFFER: hold eng_valid and eng_addr stable until eng_ready[g]=1. On that cycle: pop the buffer, set busy[g], store the address in slot[g], set rr=g, clear eng_valid on the next edge, go to IDLE.
  - eng_ready on non-offered engines is ignored.
  - Throughput: at most one dispatch every 2 cycles.
- Completion:
  - eng_done[i] with busy[i]=1 sets pend[i].
  - eng_done[i] with busy[i]=0 is ignored and sets err[1]. This includes done arriving in the same cycle as the accept handshake for that engine.
- Free emitter: each cycle, if any pend bit is set, take the lowest index i. Next edge: free_addr_v=1, free_addr=slot[i], clear pend[i] and busy[i]. Other pending engines wait one cycle each.
- Simultaneous handling: buffer write and pop in the same cycle leave buf_count unchanged; the buffer wraps modulo BUF_DEPTH. busy clear and a new dispatch to the same engine cannot overlap, because idle status is sampled from registered busy.

Decomposition:
- Package tfe_dispatch_pkg holds:
  - the ADDR_W default;
  - the FSM state enum {IDLE, OFFER};
  - the err bit index constants.
- Sub-module tfe_fea_buf: synchronous FIFO (BUF_DEPTH x ADDR_W) with count, full and empty.
- The round-robin pick and the lowest-index free priority are coded inline.

Test Plan:
1. FIFO holds 3 addrs (0x010, 0x011, 0x012), all engines idle, ready tied 1 -> rd_fifo for 3 cycles. Dispatch order eng0 0x010, eng1 0x011, eng2 0x012. Each fea_addr_v arrives exactly READ_LAT cycles after its rd_fifo.
2. BUF_DEPTH=4, all engines busy, FIFO non-empty -> exactly 4 pops; rd_fifo stays low with buf_count=4. err[0] never set.
3. eng1 holds eng_ready low for 5 cycles -> eng_valid[1] and eng_addr stay stable for all 5 cycles. The buffer is popped only on the ready cycle.
4. eng0, eng2 and eng3 pulse eng_done in the same cycle -> free_addr_v on 3 consecutive cycles, in order slot0, slot2, slot3. busy bits clear in that order.
5. eng_done[3] while eng3 is idle -> err[1]=1, no free pulse, sticky until reset.
6. Assert rst_n low during OFFER with 2 pops in flight -> outputs are 0 immediately. After release the late fea_addr_v are absorbed, with no err[0] and no dispatch until new data arrives.
